// File: rtl/ex_stage.sv
// Execute stage: ID/EX and EX/MEM pipeline registers around the ALU, with operand
// forwarding muxes and hold registers that keep forwarded operands stable across stalls.
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic [XLEN-1:0] id_rs1_val,
  input  logic [XLEN-1:0] id_rs2_val,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [3:0]      id_alu_op,
  input  logic            id_alu_src_imm,
  input  logic            id_alu_src_pc,
  input  logic            stall,
  input  logic            flush,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic [XLEN-1:0] wb_fwd_data,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic            mem_valid,
  output logic            mem_reg_write,
  output logic            mem_mem_read,
  output logic            mem_mem_write,
  output logic [XLEN-1:0] mem_alu_result,
  output logic [XLEN-1:0] mem_store_data,
  output logic [4:0]      mem_rd
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            alu_src_imm;
    logic            alu_src_pc;
    logic [3:0]      alu_op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } id_ex_t;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [4:0]      rd;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
  } ex_mem_t;

  id_ex_t          id_ex, id_in;
  ex_mem_t         ex_mem, ex_next;
  logic [XLEN-1:0] hold_a, hold_b;
  logic            held;
  logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b, alu_result;
  logic [SHW-1:0]  shamt;

  // An invalid ID slot becomes an all-zero bubble regardless of its other fields.
  always_comb begin
    // NOTE: default every always_comb output first so no path can infer a latch.
    id_in = '0;
    if (id_valid) begin
      id_in.valid       = 1'b1;
      id_in.reg_write   = id_reg_write;
      id_in.mem_read    = id_mem_read;
      id_in.mem_write   = id_mem_write;
      id_in.alu_src_imm = id_alu_src_imm;
      id_in.alu_src_pc  = id_alu_src_pc;
      id_in.alu_op      = id_alu_op;
      id_in.rs1         = id_rs1;
      id_in.rs2         = id_rs2;
      id_in.rd          = id_rd;
      id_in.rs1_val     = id_rs1_val;
      id_in.rs2_val     = id_rs2_val;
      id_in.imm         = id_imm;
      id_in.pc          = id_pc;
    end
  end

  // Code 11 falls back to the ID/EX value, like 00.
  always_comb begin
    fwd_a = id_ex.rs1_val;
    fwd_b = id_ex.rs2_val;
    if (held) begin
      fwd_a = hold_a;
      fwd_b = hold_b;
    end else begin
      case (forward_a)
        2'b10:   fwd_a = mem_fwd_data;
        2'b01:   fwd_a = wb_fwd_data;
        default: fwd_a = id_ex.rs1_val;
      endcase
      case (forward_b)
        2'b10:   fwd_b = mem_fwd_data;
        2'b01:   fwd_b = wb_fwd_data;
        default: fwd_b = id_ex.rs2_val;
      endcase
    end
  end

  assign op_a  = id_ex.alu_src_pc  ? id_ex.pc  : fwd_a;
  assign op_b  = id_ex.alu_src_imm ? id_ex.imm : fwd_b;
  assign shamt = op_b[SHW-1:0];

  always_comb begin
    alu_result = '0;
    case (id_ex.alu_op)
      ALU_ADD:   alu_result = op_a + op_b;
      ALU_SUB:   alu_result = op_a - op_b;
      ALU_AND:   alu_result = op_a & op_b;
      ALU_OR:    alu_result = op_a | op_b;
      ALU_XOR:   alu_result = op_a ^ op_b;
      ALU_SLL:   alu_result = op_a << shamt;
      ALU_SRL:   alu_result = op_a >> shamt;
      ALU_SRA:   alu_result = $unsigned($signed(op_a) >>> shamt);
      ALU_SLT:   alu_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:  alu_result = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_PASSB: alu_result = op_b;
      default:   alu_result = '0;
    endcase
  end

  // A bubble in EX must leave a fully zero EX/MEM entry, data included.
  always_comb begin
    ex_next = '0;
    if (id_ex.valid) begin
      ex_next.valid      = 1'b1;
      ex_next.reg_write  = id_ex.reg_write;
      ex_next.mem_read   = id_ex.mem_read;
      ex_next.mem_write  = id_ex.mem_write;
      ex_next.rd         = id_ex.rd;
      ex_next.alu_result = alu_result;
      ex_next.store_data = fwd_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      id_ex  <= '0;
      ex_mem <= '0;
      hold_a <= '0;
      hold_b <= '0;
      held   <= 1'b0;
    end else if (flush) begin
      id_ex  <= '0;
      ex_mem <= '0;
      held   <= 1'b0;
    end else if (stall) begin
      ex_mem <= '0;
      // Capture only on the first stall cycle; forward codes go stale afterwards.
      if (!held) begin
        hold_a <= fwd_a;
        hold_b <= fwd_b;
        held   <= 1'b1;
      end
    end else begin
      ex_mem <= ex_next;
      id_ex  <= id_in;
      held   <= 1'b0;
    end
  end

  assign ex_rs1         = id_ex.rs1;
  assign ex_rs2         = id_ex.rs2;
  assign mem_valid      = ex_mem.valid;
  assign mem_reg_write  = ex_mem.reg_write;
  assign mem_mem_read   = ex_mem.mem_read;
  assign mem_mem_write  = ex_mem.mem_write;
  assign mem_rd         = ex_mem.rd;
  assign mem_alu_result = ex_mem.alu_result;
  assign mem_store_data = ex_mem.store_data;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: an ALU vector table plus hand-written forwarding,
// stall-hold, flush and reset sequences.
module tb_ex_stage;

  logic        clk, rst_n;
  logic        id_valid, id_reg_write, id_mem_read, id_mem_write;
  logic [31:0] id_rs1_val, id_rs2_val, id_imm, id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic        id_alu_src_imm, id_alu_src_pc;
  logic        stall, flush;
  logic [1:0]  forward_a, forward_b;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic [4:0]  ex_rs1, ex_rs2;
  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
  logic [31:0] mem_alu_result, mem_store_data;
  logic [4:0]  mem_rd;

  int total = 0;
  int bad   = 0;

  ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_alu_src_imm(id_alu_src_imm), .id_alu_src_pc(id_alu_src_pc),
    .stall(stall), .flush(flush), .forward_a(forward_a), .forward_b(forward_b),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data), .mem_rd(mem_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        src_imm;
    logic        src_pc;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];
  int   nvec;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    id_rs1_val = 0; id_rs2_val = 0; id_imm = 0; id_pc = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_op = 0;
    id_alu_src_imm = 0; id_alu_src_pc = 0;
  endtask

  task automatic set_add(input logic [4:0] rs1, input logic [31:0] v1, input logic [31:0] v2);
    clear_id();
    id_valid = 1; id_reg_write = 1; id_alu_op = 4'd0;
    id_rs1 = rs1; id_rs2 = 5'd2; id_rd = 5'd9;
    id_rs1_val = v1; id_rs2_val = v2;
  endtask

  initial begin
    vecs[0]  = '{4'd0,  32'h0000_0003, 32'h0000_0004, 32'h0, 32'h0,   1'b0, 1'b0, 32'h0000_0007};
    vecs[1]  = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0, 32'h0,   1'b0, 1'b0, 32'h0000_0001};
    vecs[2]  = '{4'd1,  32'h0000_0000, 32'h0000_0001, 32'h0, 32'h0,   1'b0, 1'b0, 32'hFFFF_FFFF};
    vecs[3]  = '{4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'h0,   1'b0, 1'b0, 32'hF000_F000};
    vecs[4]  = '{4'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'h0,   1'b0, 1'b0, 32'hFFF0_FFF0};
    vecs[5]  = '{4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'h0,   1'b0, 1'b0, 32'h0FF0_0FF0};
    vecs[6]  = '{4'd5,  32'h0000_0001, 32'h0000_001F, 32'h0, 32'h0,   1'b0, 1'b0, 32'h8000_0000};
    vecs[7]  = '{4'd5,  32'h0000_0001, 32'h0000_0024, 32'h0, 32'h0,   1'b0, 1'b0, 32'h0000_0010};
    vecs[8]  = '{4'd6,  32'h8000_0000, 32'h0000_0004, 32'h0, 32'h0,   1'b0, 1'b0, 32'h0800_0000};
    vecs[9]  = '{4'd7,  32'h8000_0000, 32'h0000_0004, 32'h0, 32'h0,   1'b0, 1'b0, 32'hF800_0000};
    vecs[10] = '{4'd8,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 32'h0,   1'b0, 1'b0, 32'h0000_0001};
    vecs[11] = '{4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 32'h0,   1'b0, 1'b0, 32'h0000_0000};
    vecs[12] = '{4'd9,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 32'h0,   1'b0, 1'b0, 32'h0000_0001};
    vecs[13] = '{4'd10, 32'hDEAD_BEEF, 32'h0000_0055, 32'h1234_5000, 32'h0, 1'b1, 1'b0, 32'h1234_5000};
    vecs[14] = '{4'd0,  32'hDEAD_BEEF, 32'h0000_0055, 32'h0000_0004, 32'h100, 1'b1, 1'b1, 32'h0000_0104};
    vecs[15] = '{4'd15, 32'h1234_5678, 32'h0000_0001, 32'h0, 32'h0,   1'b0, 1'b0, 32'h0000_0000};
    nvec = 16;

    clear_id();
    stall = 0; flush = 0; forward_a = 0; forward_b = 0;
    mem_fwd_data = 0; wb_fwd_data = 0;
    rst_n = 0;
    #12;
    check("reset_outputs",
          {mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_rd, ex_rs1, ex_rs2, mem_alu_result},
          64'h0);
    check("reset_store_data", {32'h0, mem_store_data}, 64'h0);
    rst_n = 1;
    step();
    step();
    check("idle_mem_valid", {63'h0, mem_valid}, 64'h0);

    // ALU table: accept at one edge, result on mem_* after the next.
    for (int i = 0; i < nvec; i++) begin
      clear_id();
      id_valid = 1; id_reg_write = 1; id_mem_read = (i % 2 == 1); id_mem_write = (i % 3 == 0);
      id_alu_op = vecs[i].op; id_rs1_val = vecs[i].a; id_rs2_val = vecs[i].b;
      id_imm = vecs[i].imm; id_pc = vecs[i].pc;
      id_alu_src_imm = vecs[i].src_imm; id_alu_src_pc = vecs[i].src_pc;
      id_rs1 = 5'(i + 1); id_rs2 = 5'(i + 2); id_rd = 5'(i + 3);
      step();
      check($sformatf("vec%0d_ex_rs", i), {54'h0, ex_rs1, ex_rs2}, {54'h0, 5'(i + 1), 5'(i + 2)});
      clear_id();
      step();
      check($sformatf("vec%0d_result", i), {32'h0, mem_alu_result}, {32'h0, vecs[i].exp});
      check($sformatf("vec%0d_store", i), {32'h0, mem_store_data}, {32'h0, vecs[i].b});
      check($sformatf("vec%0d_ctrl", i),
            {55'h0, mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_rd},
            {55'h0, 1'b1, 1'b1, 1'(i % 2 == 1), 1'(i % 3 == 0), 5'(i + 3)});
    end
    step();
    check("bubble_after_table", {63'h0, mem_valid}, 64'h0);

    // MEM forward on A: 5 + 7 = 12, store data stays rs2_val.
    set_add(5'd1, 32'd1, 32'd7);
    step();
    check("latency_not_yet", {63'h0, mem_valid}, 64'h0);
    clear_id();
    forward_a = 2'b10; mem_fwd_data = 32'd5;
    step();
    check("fwd_mem_result", {32'h0, mem_alu_result}, 64'd12);
    check("fwd_mem_store", {32'h0, mem_store_data}, 64'd7);
    check("fwd_mem_valid", {63'h0, mem_valid}, 64'd1);

    // WB forward on B feeds both the adder and store data; code 11 on A uses rs1_val.
    set_add(5'd1, 32'd100, 32'd7);
    forward_a = 2'b00; mem_fwd_data = 0;
    step();
    clear_id();
    forward_a = 2'b11; forward_b = 2'b01; mem_fwd_data = 32'hAAAA; wb_fwd_data = 32'd20;
    step();
    check("fwd_wb_result", {32'h0, mem_alu_result}, 64'd120);
    check("fwd_wb_store", {32'h0, mem_store_data}, 64'd20);
    forward_a = 0; forward_b = 0; mem_fwd_data = 0; wb_fwd_data = 0;

    // Stall capture: operand A captured from MEM on the first stall cycle only.
    set_add(5'd5, 32'h100, 32'h1);
    step();
    clear_id();
    stall = 1; forward_a = 2'b10; mem_fwd_data = 32'h10;
    step();
    check("stall1_valid", {63'h0, mem_valid}, 64'h0);
    forward_a = 2'b00; mem_fwd_data = 32'hFF;
    step();
    check("stall2_valid", {63'h0, mem_valid}, 64'h0);
    check("stall2_ex_rs1", {59'h0, ex_rs1}, 64'd5);
    step();
    check("stall3_valid", {63'h0, mem_valid}, 64'h0);
    stall = 0;
    step();
    check("stall_release_result", {32'h0, mem_alu_result}, 64'h11);
    check("stall_release_valid", {63'h0, mem_valid}, 64'h1);
    mem_fwd_data = 0;
    step();
    check("stall_done_bubble", {63'h0, mem_valid}, 64'h0);

    // Flush with stall: both the EX instruction and the ID instruction die.
    set_add(5'd3, 32'd1, 32'd1);
    step();
    set_add(5'd4, 32'd2, 32'd2);
    flush = 1; stall = 1;
    step();
    check("flush_valid", {63'h0, mem_valid}, 64'h0);
    check("flush_ex_rs1", {59'h0, ex_rs1}, 64'h0);
    flush = 0; stall = 0;
    clear_id();
    step();
    check("flush_next_valid", {63'h0, mem_valid}, 64'h0);

    // Reset while held: the stale hold value must not leak into the next instruction.
    set_add(5'd6, 32'h50, 32'h0);
    step();
    clear_id();
    stall = 1; forward_a = 2'b10; mem_fwd_data = 32'h999;
    step();
    #2 rst_n = 0;
    #1 rst_n = 1;
    stall = 0; forward_a = 2'b00; mem_fwd_data = 0;
    step();
    set_add(5'd7, 32'd2, 32'd3);
    step();
    clear_id();
    step();
    check("post_reset_hold_result", {32'h0, mem_alu_result}, 64'd5);
    check("post_reset_hold_valid", {63'h0, mem_valid}, 64'd1);

    // Asynchronous reset mid-cycle clears a live EX/MEM entry immediately.
    set_add(5'd8, 32'd4, 32'd4);
    step();
    clear_id();
    step();
    check("pre_async_valid", {63'h0, mem_valid}, 64'd1);
    #2 rst_n = 0;
    #1;
    check("async_reset_outputs",
          {mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_rd, ex_rs1, ex_rs2, mem_alu_result},
          64'h0);
    check("async_reset_store", {32'h0, mem_store_data}, 64'h0);
    #1 rst_n = 1;
    step();
    step();
    check("after_release_idle", {63'h0, mem_valid}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage RISC-V pipeline: owns the ID/EX and EX/MEM pipeline registers and the ALU between them. It consumes the 2-bit operand-select codes from the ALU data forwarding unit. It publishes the source register numbers that unit compares against MEM/WB destinations. It also holds forwarded operands across EX stalls so results stay correct while MEM/WB keep draining.

## Interface
- XLEN, 32, datapath width; shift amount is the low log2(XLEN) bits of operand B
- clk  in  1  pipeline clock, all state updates on rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- id_valid, id_reg_write, id_mem_read, id_mem_write  in  1 each  decode-stage instruction valid and control bits
- id_rs1_val, id_rs2_val, id_imm, id_pc  in  XLEN each  register-file read data, sign-extended immediate, PC
- id_rs1, id_rs2, id_rd  in  5 each  register numbers
- id_alu_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 PASSB; others give result 0
- id_alu_src_imm, id_alu_src_pc  in  1 each  operand B = imm; operand A = pc
- stall  in  1  hold EX instruction and accept nothing from ID
- flush  in  1  kill EX instruction and incoming ID instruction
- forward_a, forward_b  in  2 each  00 ID/EX value, 10 MEM result, 01 WB result, 11 treated as 00
- mem_fwd_data, wb_fwd_data  in  XLEN each  forwarding sources
- ex_rs1, ex_rs2  out  5 each  register numbers of instruction in EX; 0 when EX holds a bubble
- mem_valid, mem_reg_write, mem_mem_read, mem_mem_write  out  1 each  EX/MEM control
- mem_alu_result, mem_store_data  out  XLEN each  ALU result; forwarded rs2 value
- mem_rd  out  5  destination register

## Operation
- Bubble: valid=0, all control bits 0, rd/rs1/rs2=0, data fields 0. A load with id_valid=0 loads a bubble, whatever the other id_* values are.
- Resolved operand: fwd_x = held value if held flag set; else by forward code: ID/EX rsx_val, mem_fwd_data, or wb_fwd_data.
- opA = alu_src_pc ? pc : fwd_a. opB = alu_src_imm ? imm : fwd_b. store data = fwd_b, always.
- All arithmetic is modulo 2^XLEN.
- SLT is signed; SLTU is unsigned; both give result 1 or 0.
- SRA replicates opA[XLEN-1].
- PASSB gives opB (LUI).
- Per-cycle update, in priority order:
  - flush: ID/EX <= bubble, EX/MEM <= bubble, held flag cleared.
  - stall: ID/EX holds, EX/MEM <= bubble. On the first stall cycle (held=0), capture fwd_a/fwd_b into hold registers and set held=1. Later stall cycles ignore forward_a/b.
  - otherwise: EX/MEM <= ALU result and controls of the ID/EX instruction, using the resolved operands. ID/EX <= id_* inputs. held cleared.
- Stalling a bubble is legal. It captures don't-care operands and produces nothing.
- Reset (async, any time including mid-stall): both pipeline registers become bubbles, hold registers and held flag cleared.

## Timing
- Reset value of every output: 0.
- Latency: an instruction accepted from ID at edge N appears on mem_* after edge N+1 when no stall/flush occurs.
- Each stall cycle adds one cycle and emits one bubble (mem_valid=0).
- ex_rs1/ex_rs2 are driven directly from the ID/EX register, with no combinational path from id_*. forward_a/b may therefore depend on them in the same cycle.
- forward_a/b, mem_fwd_data and wb_fwd_data are sampled combinationally into the EX/MEM update (or hold capture) at the same edge.
- flush and stall together: flush wins.
- Back-to-back dependent instructions: no internal interlock; correctness comes from forward codes.

## Test plan
- Reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately. After release with id_valid=0 -> mem_valid stays 0.
- ADD, rs1_val=1, rs2_val=7, forward_a=10, mem_fwd_data=5 -> one cycle later mem_alu_result=12, mem_store_data=7, mem_valid=1.
- Stall capture:
  - Stimulus: ADD in EX, forward_a=10, mem_fwd_data=0x10, rs2_val=1, stall for 3 cycles. From the second stall cycle: forward_a=00, mem_fwd_data=0xFF.
  - Response: mem_valid=0 for 3 cycles, then mem_alu_result=0x11.
- Flush and stall together with a valid ADD in EX and a valid ID input -> next two edges give mem_valid=0, and ex_rs1=0 after the first edge.
- ALU corners:
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - SRL 0x80000000 by 4 -> 0x08000000.
  - SLT 0xFFFFFFFF vs 1 -> 1; SLTU -> 0.
  - SUB 0 - 1 -> 0xFFFFFFFF.
  - id_alu_op=15 -> 0.
- Reset during stall with held=1 -> after release, the next instruction with forward_a=00 uses its own rs1_val, not the stale hold value.
